// File: rtl/mmio_arbiter_if.sv
// mmio_arbiter_if
//   Bundles the two requester ports and the MMIO register-block port of
//   mmio_arbiter.
//
//   Modports:
//     slave  - arbiter view: it accepts requester transactions and drives
//              the MMIO block (takes mN_* / s_q in, drives acks and s_*).
//     master - environment view: requesters plus the MMIO block model
//              (drives mN_* requests and s_q, observes acks and s_*).
//
//   Signals (N = 0, 1):
//     mN_req, mN_addr[ADDR_W], mN_byteena[4], mN_wdata[32], mN_wren
//     mN_ack, mN_rdata[32]
//     s_address[ADDR_W], s_byteena[4], s_data[32], s_wren, s_clken, s_q[32]

interface mmio_arbiter_if #(
    parameter int ADDR_W = 14
) ();

    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic [3:0]        m0_byteena;
    logic [31:0]       m0_wdata;
    logic              m0_wren;
    logic              m0_ack;
    logic [31:0]       m0_rdata;

    logic              m1_req;
    logic [ADDR_W-1:0] m1_addr;
    logic [3:0]        m1_byteena;
    logic [31:0]       m1_wdata;
    logic              m1_wren;
    logic              m1_ack;
    logic [31:0]       m1_rdata;

    logic [ADDR_W-1:0] s_address;
    logic [3:0]        s_byteena;
    logic [31:0]       s_data;
    logic              s_wren;
    logic              s_clken;
    logic [31:0]       s_q;

    modport slave (
        input  m0_req, m0_addr, m0_byteena, m0_wdata, m0_wren,
        output m0_ack, m0_rdata,
        input  m1_req, m1_addr, m1_byteena, m1_wdata, m1_wren,
        output m1_ack, m1_rdata,
        output s_address, s_byteena, s_data, s_wren, s_clken,
        input  s_q
    );

    modport master (
        output m0_req, m0_addr, m0_byteena, m0_wdata, m0_wren,
        input  m0_ack, m0_rdata,
        output m1_req, m1_addr, m1_byteena, m1_wdata, m1_wren,
        input  m1_ack, m1_rdata,
        input  s_address, s_byteena, s_data, s_wren, s_clken,
        output s_q
    );

endinterface

// File: rtl/mmio_arbiter.sv
// mmio_arbiter
//   Two-requester arbiter in front of a single-port MMIO register block.
//   A request seen in IDLE is granted in the same cycle: the winner's
//   address/byte enables/data/write flag are driven straight onto s_* with
//   s_clken=1. The following cycle (RESP) the MMIO read data s_q is
//   returned to the winner together with a one-cycle ack. Throughput is
//   one transaction per two cycles.
//
//   Ports:
//     clock    - rising-edge clock
//     reset_n  - synchronous, active-low reset
//     bus      - mmio_arbiter_if.slave (requesters m0/m1 and MMIO s_*)
//
//   Build option:
//     MMIO_ARB_RR_EN - when defined, contention is resolved round-robin
//                      (the requester not granted last wins); otherwise
//                      m0 has fixed priority over m1 and no pointer exists.
//
//   State table:
//     IDLE | waiting for a request; grants and drives s_* combinationally
//     RESP | MMIO data is valid on s_q; acks the registered winner

module mmio_arbiter #(
    parameter int ADDR_W = 14
) (
    input  logic          clock,
    input  logic          reset_n,
    mmio_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic winner_q;
    logic winner_d;

    // Clear for the first cycle after reset so every output stays at zero
    // during that cycle even if requests are already pending.
    logic armed_q;

    logic active;
    logic any_req;
    logic grant_valid;
    logic grant_idx;

    logic [ADDR_W-1:0] addr_sel;
    logic [3:0]        be_sel;
    logic [31:0]       wdata_sel;
    logic              wren_sel;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            winner_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            armed_q  <= 1'b1;
        end
    end

    assign active      = reset_n & armed_q;
    assign any_req     = bus.m0_req | bus.m1_req;
    assign grant_valid = active & (state_q == IDLE) & any_req;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef MMIO_ARB_RR_EN
    // rr_ptr_q names the requester preferred on the next contended grant.
    logic rr_ptr_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rr_ptr_q <= 1'b0;
        end else if (grant_valid) begin
            rr_ptr_q <= ~grant_idx;
        end
    end

    always_comb begin
        grant_idx = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
            grant_idx = rr_ptr_q;
        end else begin
            grant_idx = ~bus.m0_req;
        end
    end
`else
    always_comb begin
        grant_idx = 1'b0;
        if (!bus.m0_req) begin
            grant_idx = 1'b1;
        end
    end
`endif

    // Winner's request fields, selected by the combinational grant.
    always_comb begin
        addr_sel  = bus.m0_addr;
        be_sel    = bus.m0_byteena;
        wdata_sel = bus.m0_wdata;
        wren_sel  = bus.m0_wren;
        if (grant_idx) begin
            addr_sel  = bus.m1_addr;
            be_sel    = bus.m1_byteena;
            wdata_sel = bus.m1_wdata;
            wren_sel  = bus.m1_wren;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        winner_d      = winner_q;
        bus.s_address = '0;
        bus.s_byteena = 4'b0000;
        bus.s_data    = 32'h0;
        bus.s_wren    = 1'b0;
        bus.s_clken   = 1'b0;
        bus.m0_ack    = 1'b0;
        bus.m0_rdata  = 32'h0;
        bus.m1_ack    = 1'b0;
        bus.m1_rdata  = 32'h0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d       = RESP;
                    winner_d      = grant_idx;
                    bus.s_clken   = 1'b1;
                    bus.s_address = addr_sel;
                    bus.s_byteena = be_sel;
                    bus.s_data    = wdata_sel;
                    bus.s_wren    = wren_sel;
                end
            end

            RESP: begin
                state_d = IDLE;
                // Ack does not look at mN_req: a winner that dropped its
                // request still gets exactly one completion. A reset
                // arriving in this cycle swallows the ack.
                if (reset_n) begin
                    if (winner_q) begin
                        bus.m1_ack   = 1'b1;
                        bus.m1_rdata = bus.s_q;
                    end else begin
                        bus.m0_ack   = 1'b1;
                        bus.m0_rdata = bus.s_q;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mmio_arbiter.sv
// tb_mmio_arbiter
//   Directed bench for mmio_arbiter. A small MMIO register-block model
//   returns registered read data (old value on writes) one cycle after
//   s_clken. Expected values are hand-computed constants; contention
//   expectations follow the MMIO_ARB_RR_EN build setting.

module tb_mmio_arbiter;

    localparam int ADDR_W = 14;

    logic clock;
    logic reset_n;

    int n_checks;
    int n_fail;

    mmio_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mmio_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // MMIO register block model: 16 words, byte-enabled writes, s_q holds
    // the pre-write value of the addressed word.
    logic [31:0] mem [0:15];

    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h0000_02A5;
            mem[1] <= 32'h1122_3344;
        end else if (bus.s_clken) begin
            bus.s_q <= mem[bus.s_address[3:0]];
            if (bus.s_wren) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.s_byteena[b])
                        mem[bus.s_address[3:0]][8*b +: 8] <= bus.s_data[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_m0(input logic req, input logic [ADDR_W-1:0] addr,
                          input logic wren, input logic [3:0] be, input logic [31:0] wd);
        bus.m0_req     = req;
        bus.m0_addr    = addr;
        bus.m0_wren    = wren;
        bus.m0_byteena = be;
        bus.m0_wdata   = wd;
    endtask

    task automatic set_m1(input logic req, input logic [ADDR_W-1:0] addr,
                          input logic wren, input logic [3:0] be, input logic [31:0] wd);
        bus.m1_req     = req;
        bus.m1_addr    = addr;
        bus.m1_wren    = wren;
        bus.m1_byteena = be;
        bus.m1_wdata   = wd;
    endtask

    int clken_cnt;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        bus.s_q  = 32'h0;
        set_m0(1'b0, 14'h0, 1'b0, 4'h0, 32'h0);
        set_m1(1'b0, 14'h0, 1'b0, 4'h0, 32'h0);

        // ---- reset and first cycle after reset --------------------------
        tick(); tick(); tick();
        set_m0(1'b1, 14'h0005, 1'b0, 4'hF, 32'h0);
        set_m1(1'b1, 14'h0009, 1'b0, 4'hF, 32'h0);
        #1;
        chk("rst_clken", {31'h0, bus.s_clken}, 32'h0);
        chk("rst_ack0",  {31'h0, bus.m0_ack},  32'h0);
        chk("rst_ack1",  {31'h0, bus.m1_ack},  32'h0);
        chk("rst_addr",  {18'h0, bus.s_address}, 32'h0);
        reset_n = 1'b1;
        #1;
        chk("first_clken", {31'h0, bus.s_clken}, 32'h0);
        chk("first_addr",  {18'h0, bus.s_address}, 32'h0);
        tick();
        chk("init_clken", {31'h0, bus.s_clken}, 32'h1);
        chk("init_addr",  {18'h0, bus.s_address}, 32'h5);
        tick();
        chk("init_ack0", {31'h0, bus.m0_ack}, 32'h1);
        chk("init_ack1", {31'h0, bus.m1_ack}, 32'h0);
        set_m0(1'b0, 14'h0, 1'b0, 4'h0, 32'h0);
        set_m1(1'b0, 14'h0, 1'b0, 4'h0, 32'h0);
        tick();
        chk("idle_clken", {31'h0, bus.s_clken}, 32'h0);
        chk("idle_wren",  {31'h0, bus.s_wren},  32'h0);
        chk("idle_addr",  {18'h0, bus.s_address}, 32'h0);
        chk("idle_data",  bus.s_data, 32'h0);

        // ---- single read by m0 ------------------------------------------
        set_m0(1'b1, 14'h0004, 1'b0, 4'hF, 32'h0);
        #1;
        chk("rd_clken", {31'h0, bus.s_clken}, 32'h1);
        chk("rd_addr",  {18'h0, bus.s_address}, 32'h4);
        chk("rd_wren",  {31'h0, bus.s_wren}, 32'h0);
        tick();
        chk("rd_resp_clken", {31'h0, bus.s_clken}, 32'h0);
        chk("rd_ack0",   {31'h0, bus.m0_ack}, 32'h1);
        chk("rd_rdata0", bus.m0_rdata, 32'h0000_02A5);
        chk("rd_ack1",   {31'h0, bus.m1_ack}, 32'h0);
        chk("rd_rdata1", bus.m1_rdata, 32'h0);
        set_m0(1'b0, 14'h0, 1'b0, 4'h0, 32'h0);
        tick();

        // ---- single write by m1 -----------------------------------------
        set_m1(1'b1, 14'h0001, 1'b1, 4'b0011, 32'h0000_03FF);
        #1;
        chk("wr_clken", {31'h0, bus.s_clken}, 32'h1);
        chk("wr_wren",  {31'h0, bus.s_wren}, 32'h1);
        chk("wr_addr",  {18'h0, bus.s_address}, 32'h1);
        chk("wr_data",  bus.s_data, 32'h0000_03FF);
        chk("wr_be",    {28'h0, bus.s_byteena}, 32'h3);
        tick();
        chk("wr_resp_clken", {31'h0, bus.s_clken}, 32'h0);
        chk("wr_resp_wren",  {31'h0, bus.s_wren}, 32'h0);
        chk("wr_ack1",   {31'h0, bus.m1_ack}, 32'h1);
        chk("wr_ack0",   {31'h0, bus.m0_ack}, 32'h0);
        chk("wr_rdata1", bus.m1_rdata, 32'h1122_3344);
        chk("wr_rdata0", bus.m0_rdata, 32'h0);
        set_m1(1'b0, 14'h0, 1'b0, 4'h0, 32'h0);
        tick();

        // ---- contention: both request continuously ----------------------
        set_m0(1'b1, 14'h0002, 1'b0, 4'hF, 32'h0);
        set_m1(1'b1, 14'h0003, 1'b0, 4'hF, 32'h0);
        for (int c = 1; c <= 8; c++) begin
            logic e0, e1;
            #1;
`ifdef MMIO_ARB_RR_EN
            e0 = (c % 4 == 2);
            e1 = (c % 4 == 0);
`else
            e0 = (c % 2 == 0);
            e1 = 1'b0;
`endif
            chk($sformatf("cont_ack0_c%0d", c), {31'h0, bus.m0_ack}, {31'h0, e0});
            chk($sformatf("cont_ack1_c%0d", c), {31'h0, bus.m1_ack}, {31'h0, e1});
            tick();
        end
        set_m0(1'b0, 14'h0, 1'b0, 4'h0, 32'h0);
        #1;
        chk("m0_idle_grant_clken", {31'h0, bus.s_clken}, 32'h1);
        chk("m0_idle_grant_addr",  {18'h0, bus.s_address}, 32'h3);
        tick();
        chk("m0_idle_ack1", {31'h0, bus.m1_ack}, 32'h1);
        chk("m0_idle_ack0", {31'h0, bus.m0_ack}, 32'h0);
        set_m1(1'b0, 14'h0, 1'b0, 4'h0, 32'h0);
        tick();

        // ---- read back the written word (byte-enabled merge) ------------
        set_m0(1'b1, 14'h0001, 1'b0, 4'hF, 32'h0);
        tick();
        chk("rb_ack0",   {31'h0, bus.m0_ack}, 32'h1);
        chk("rb_rdata0", bus.m0_rdata, 32'h1122_03FF);
        set_m0(1'b0, 14'h0, 1'b0, 4'h0, 32'h0);
        tick();

        // ---- reset during RESP ------------------------------------------
        set_m1(1'b1, 14'h0007, 1'b0, 4'hF, 32'h0);
        tick();
        reset_n = 1'b0;
        #1;
        chk("rstresp_ack1",   {31'h0, bus.m1_ack}, 32'h0);
        chk("rstresp_rdata1", bus.m1_rdata, 32'h0);
        tick();
        reset_n = 1'b1;
        set_m0(1'b1, 14'h0006, 1'b0, 4'hF, 32'h0);
        #1;
        chk("rstresp_first_clken", {31'h0, bus.s_clken}, 32'h0);
        chk("rstresp_first_ack1",  {31'h0, bus.m1_ack}, 32'h0);
        tick();
        chk("rstresp_grant_clken", {31'h0, bus.s_clken}, 32'h1);
        chk("rstresp_grant_addr",  {18'h0, bus.s_address}, 32'h6);
        tick();
        chk("rstresp_ack0", {31'h0, bus.m0_ack}, 32'h1);
        chk("rstresp_ack1b", {31'h0, bus.m1_ack}, 32'h0);
        set_m0(1'b0, 14'h0, 1'b0, 4'h0, 32'h0);
        tick();
        chk("pend_clken", {31'h0, bus.s_clken}, 32'h1);
        chk("pend_addr",  {18'h0, bus.s_address}, 32'h7);
        tick();
        chk("pend_ack1", {31'h0, bus.m1_ack}, 32'h1);
        set_m1(1'b0, 14'h0, 1'b0, 4'h0, 32'h0);
        tick();

        // ---- early drop: m0 releases req during RESP --------------------
        clken_cnt = 0;
        set_m0(1'b1, 14'h0004, 1'b0, 4'hF, 32'h0);
        #1;
        if (bus.s_clken) clken_cnt++;
        tick();
        set_m0(1'b0, 14'h0004, 1'b0, 4'hF, 32'h0);
        #1;
        chk("drop_ack0",   {31'h0, bus.m0_ack}, 32'h1);
        chk("drop_rdata0", bus.m0_rdata, 32'h0000_02A5);
        if (bus.s_clken) clken_cnt++;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.s_clken) clken_cnt++;
            chk($sformatf("drop_noack_%0d", k), {31'h0, bus.m0_ack}, 32'h0);
        end
        chk("drop_clken_pulses", clken_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
